// File: rtl/stack_mem_arbiter_pkg.sv
// Shared types and constants for the two-port stack memory arbiter.
package arb_pkg;

  localparam int unsigned MEM_LAT_MAX = 4;
  localparam int unsigned CNT_W       = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    OWN_CPU,
    OWN_LDR
  } owner_e;

endpackage

// File: rtl/stack_mem_arbiter_if.sv
// Request/grant ports of the CPU and loader plus the memory-side bus.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface stack_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;
  logic [DATA_W-1:0] ldr_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output ldr_gnt, ldr_rvalid, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ldr_gnt, ldr_rvalid, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/stack_mem_arbiter.sv
// Round-robin arbiter sharing one memory between the CPU datapath and the
// program loader; tracks read latency and returns registered read data.
module stack_mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  stack_mem_arbiter_if.slave  bus,
  output logic                busy
);

  state_e            state_q;
  owner_e            last_q;
  owner_e            owner_q;
  owner_e            win_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              cpu_gnt_q;
  logic              ldr_gnt_q;
  logic              cpu_rvalid_q;
  logic              ldr_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ldr_rdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              busy_q;

  // On a tie the port that did not win last time gets the memory.
  always_comb begin
    win_d = OWN_CPU;
    if (bus.cpu_req && bus.ldr_req) begin
      win_d = (last_q == OWN_CPU) ? OWN_LDR : OWN_CPU;
    end else if (bus.ldr_req) begin
      win_d = OWN_LDR;
    end
  end

  // mem_addr_q/mem_wdata_q double as the latched payload; mem_we_q holds the
  // latched direction while in ACCESS and is cleared on leaving it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_q       <= OWN_LDR;
      owner_q      <= OWN_CPU;
      cnt_q        <= '0;
      cpu_gnt_q    <= 1'b0;
      ldr_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      cpu_gnt_q    <= 1'b0;
      ldr_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cpu_req || bus.ldr_req) begin
            state_q     <= ACCESS;
            owner_q     <= win_d;
            last_q      <= win_d;
            cpu_gnt_q   <= (win_d == OWN_CPU);
            ldr_gnt_q   <= (win_d == OWN_LDR);
            mem_en_q    <= 1'b1;
            mem_we_q    <= (win_d == OWN_CPU) ? bus.cpu_we    : bus.ldr_we;
            mem_addr_q  <= (win_d == OWN_CPU) ? bus.cpu_addr  : bus.ldr_addr;
            mem_wdata_q <= (win_d == OWN_CPU) ? bus.cpu_wdata : bus.ldr_wdata;
            busy_q      <= 1'b1;
          end
        end
        ACCESS: begin
          if (mem_we_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= CNT_W'(MEM_LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            if (owner_q == OWN_CPU) begin
              cpu_rdata_q  <= bus.mem_rdata;
              cpu_rvalid_q <= 1'b1;
            end else begin
              ldr_rdata_q  <= bus.mem_rdata;
              ldr_rvalid_q <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_gnt    = cpu_gnt_q;
  assign bus.ldr_gnt    = ldr_gnt_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.ldr_rvalid = ldr_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.ldr_rdata  = ldr_rdata_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign busy           = busy_q;

endmodule

// File: doc/stack_mem_arbiter.md
# stack_mem_arbiter

Two-port memory arbiter in front of the stack CPU's single 8-bit memory. It shares the memory between the CPU datapath port and the program-loader port. Each requester uses a req/gnt handshake. Contention is resolved round-robin, and the arbiter owns the memory enable, address, write data and read-latency tracking. It sits between `Datapath`/loader and the memory macro inside `top`.

## Interface
- `ADDR_W`, 5, memory address width
- `DATA_W`, 8, memory data width
- `MEM_LAT`, 1, memory read latency in cycles after `mem_en`; legal range 1..4
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `cpu_req` / `ldr_req`  in  1  access request; held with payload until `*_gnt`
- `cpu_we` / `ldr_we`  in  1  1 = write, 0 = read
- `cpu_addr` / `ldr_addr`  in  ADDR_W  access address
- `cpu_wdata` / `ldr_wdata`  in  DATA_W  write data
- `cpu_gnt` / `ldr_gnt`  out  1  one-cycle pulse: request accepted
- `cpu_rvalid` / `ldr_rvalid`  out  1  one-cycle pulse: read data valid
- `cpu_rdata` / `ldr_rdata`  out  DATA_W  registered read data
- `mem_en`  out  1  memory access strobe, one cycle per access
- `mem_we`  out  1  memory write enable, qualified by `mem_en`
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid `MEM_LAT` cycles after `mem_en`
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- **FSM states:** IDLE, ACCESS, WAIT, RESP.
- **IDLE:** accept a request if any `*_req` is high.
  - Select the winner, latch its `we`/`addr`/`wdata` and the owner ID, then go to ACCESS.
- **Arbitration:** a single requester always wins.
  - If both request, the winner is the port not granted last.
  - The last-grant pointer updates only on acceptance.
- **ACCESS:** owner's `gnt`=1, `mem_en`=1, `mem_*` driven from the latched payload.
  - Write: next state is IDLE.
  - Read: load the latency counter with `MEM_LAT-1`, next state is WAIT.
- **WAIT:** decrement the counter.
  - When the counter reaches 0, capture `mem_rdata` into the owner's `rdata` register and go to RESP.
  - With `MEM_LAT`=1, capture happens in the first WAIT cycle.
- **RESP:** owner's `rvalid`=1, next state is IDLE.
- **Read data:** the non-owner's `rdata` is unchanged. Each `*_rdata` holds its value until that port's next read response.
- **Requester rule:** a requester deasserts `req` or presents a new request no earlier than the cycle after `gnt`. `req` seen during ACCESS/WAIT/RESP is ignored until IDLE.
- **Outputs outside ACCESS:** `mem_en`=0 and `mem_we`=0. `mem_addr`/`mem_wdata` hold their last values.

## Timing
- **Reset:** `rst` low clears asynchronously, regardless of state.
  - State = IDLE; last-grant = loader, so the CPU wins the first tie.
  - Counter = 0.
  - All outputs = 0, including `*_rdata`, `mem_addr`, `mem_wdata` and `busy`.
  - An in-flight access is abandoned with no `gnt`/`rvalid` emitted.
- **Write:** `req` sampled in IDLE at cycle 0; `gnt` + `mem_en` in cycle 1; IDLE in cycle 2.
  - Next grant is no earlier than cycle 3.
- **Read:** `req` at cycle 0; `gnt` + `mem_en` in cycle 1; `rvalid` in cycle 2+`MEM_LAT`; IDLE in cycle 3+`MEM_LAT`.
- **Throughput:** writes accept one access per 2 cycles; reads accept one per `MEM_LAT`+3 cycles.
- **Simultaneous requests:** both requests rising in the same IDLE cycle are resolved by the pointer. The loser keeps `req` high and is granted at the next IDLE.
- **Exclusivity:** `cpu_gnt` and `ldr_gnt` are never high together, and neither are `cpu_rvalid` and `ldr_rvalid`.

## Structure
- **Shared package `arb_pkg`:** holds
  - the state enum typedef (IDLE, ACCESS, WAIT, RESP),
  - the owner enum (OWN_CPU, OWN_LDR),
  - `MEM_LAT_MAX`=4 and the counter width constant (2 bits).
- **No sub-module:** the 2-way round-robin pick and the latency counter are inline. Expected size is ~150–220 lines.

## Test plan
- **Reset:** assert `rst`=0 mid-read (WAIT) → all outputs 0 immediately; after release the next CPU read proceeds normally with no stale `rvalid`.
- **CPU write:** CPU write addr 5'h03 data 8'hA5 → `cpu_gnt` and `mem_en`/`mem_we` with addr 03, data A5 in cycle 1; `busy` low in cycle 2.
- **CPU read, `MEM_LAT`=1:** CPU read addr 5'h03, memory returns 8'hA5 → `cpu_rvalid`=1 in cycle 3 with `cpu_rdata`=A5; `ldr_rdata` unchanged.
- **Round-robin tie:** after reset, both ports request reads in the same cycle → CPU granted first; loader granted at the next IDLE; on the third contended round the CPU wins again.
- **Maximum latency, `MEM_LAT`=4:** loader read addr 5'h1F, memory returns 8'h3C → `ldr_rvalid` in cycle 6; `busy` high cycles 1–6; no `mem_en` during WAIT.
- **Back-to-back writes:** loader issues 32 writes (addr = data = i) while the CPU idles → 32 `ldr_gnt` pulses, 2 cycles apart at minimum; 32 `mem_en` pulses in order; `cpu_gnt` never asserted.
